// File: rtl/cache_set_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_set_if
// Brief    : Lookup, store, victim and refill signals of one cache set.
// Revision : 1.0  initial release
// ============================================================================
interface cache_set_if #(
    parameter int TAG_WIDTH    = 24,
    parameter int OFFSET_WIDTH = 4,
    parameter int WAYS         = 4
);
    localparam int c_ww     = $clog2(WAYS);
    localparam int c_word_w = OFFSET_WIDTH - 2;

    logic [TAG_WIDTH-1:0] tag_i;
    logic [c_word_w-1:0]  word_i;
    logic                 access_en_i;
    logic                 write_en_i;
    logic [3:0]           byte_en_i;
    logic [31:0]          write_data_i;
    logic                 hit_o;
    logic [c_ww-1:0]      hit_way_o;
    logic [31:0]          read_data_o;
    logic [c_ww-1:0]      victim_way_o;
    logic                 victim_valid_o;
    logic                 victim_dirty_o;
    logic [TAG_WIDTH-1:0] victim_tag_o;
    logic [c_word_w-1:0]  wb_word_i;
    logic [31:0]          wb_data_o;
    logic                 refill_start_i;
    logic                 refill_valid_i;
    logic [31:0]          refill_data_i;
    logic                 busy_o;
    logic                 refill_done_o;

    modport master (
        output tag_i, word_i, access_en_i, write_en_i, byte_en_i, write_data_i,
               wb_word_i, refill_start_i, refill_valid_i, refill_data_i,
        input  hit_o, hit_way_o, read_data_o, victim_way_o, victim_valid_o,
               victim_dirty_o, victim_tag_o, wb_data_o, busy_o, refill_done_o
    );

    modport slave (
        input  tag_i, word_i, access_en_i, write_en_i, byte_en_i, write_data_i,
               wb_word_i, refill_start_i, refill_valid_i, refill_data_i,
        output hit_o, hit_way_o, read_data_o, victim_way_o, victim_valid_o,
               victim_dirty_o, victim_tag_o, wb_data_o, busy_o, refill_done_o
    );
endinterface
`default_nettype wire

// File: rtl/cache_set.sv
`default_nettype none
// ============================================================================
// Module   : cache_set
// Brief    : N-way set-associative cache set with true-LRU and refill engine.
// Revision : 1.0  initial release
// ============================================================================
module cache_set #(
    parameter int TAG_WIDTH    = 24,
    parameter int OFFSET_WIDTH = 4,
    parameter int WAYS         = 4
) (
    input wire         clk_i,
    input wire         rst_ni,
    cache_set_if.slave bus
);
    localparam int c_ww        = $clog2(WAYS);
    localparam int c_word_w    = OFFSET_WIDTH - 2;
    localparam int c_line_size = 2 ** c_word_w;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [TAG_WIDTH-1:0] r_tag  [WAYS];
    logic [31:0]          r_data [WAYS][c_line_size];
    logic [c_ww-1:0]      r_age  [WAYS];
    logic [WAYS-1:0]      r_valid;
    logic [WAYS-1:0]      r_dirty;
    logic [c_word_w-1:0]  r_cnt;
    logic [TAG_WIDTH-1:0] r_fill_tag;
    logic [c_ww-1:0]      r_fill_way;
    logic                 r_done;

    logic [WAYS-1:0] w_match;
    logic            w_hit;
    logic [c_ww-1:0] w_hit_way;
    logic [c_ww-1:0] w_victim;
    logic [c_ww-1:0] w_inv_way;
    logic            w_inv_found;
    logic [c_ww-1:0] w_lru_way;
    logic [31:0]     w_merged;
    logic            w_store;
    logic            w_start;
    logic            w_beat;
    logic            w_last;
    logic            w_touch;
    logic [c_ww-1:0] w_touch_way;

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_match
            assign w_match[g] = r_valid[g] && (r_tag[g] == bus.tag_i);
        end
    endgenerate

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        if (r_state == S_IDLE) begin
            for (int i = 0; i < WAYS; i++) begin
                if (w_match[i]) begin
                    w_hit     = 1'b1;
                    w_hit_way = c_ww'(i);
                end
            end
        end
    end

    // Invalid ways take precedence over the LRU way; a refill pins the choice.
    always_comb begin
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        w_lru_way   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_ww'(i);
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            if (r_age[i] == c_ww'(WAYS - 1)) begin
                w_lru_way = c_ww'(i);
            end
        end
        if (r_state == S_FILL) begin
            w_victim = r_fill_way;
        end else if (w_inv_found) begin
            w_victim = w_inv_way;
        end else begin
            w_victim = w_lru_way;
        end
    end

    always_comb begin
        w_merged = r_data[w_hit_way][bus.word_i];
        for (int k = 0; k < 4; k++) begin
            if (bus.byte_en_i[k]) begin
                w_merged[8*k +: 8] = bus.write_data_i[8*k +: 8];
            end
        end
    end

    assign w_store     = bus.write_en_i && w_hit;
    assign w_start     = (r_state == S_IDLE) && bus.refill_start_i;
    assign w_beat      = (r_state == S_FILL) && bus.refill_valid_i;
    assign w_last      = w_beat && (r_cnt == c_word_w'(c_line_size - 1));
    assign w_touch     = (bus.access_en_i && w_hit) || w_last;
    assign w_touch_way = w_last ? r_fill_way : w_hit_way;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.refill_start_i) w_state_next = S_FILL;
            S_FILL:  if (w_last)             w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < WAYS; i++) begin
                r_tag[i] <= '0;
                r_age[i] <= c_ww'(i);
                for (int j = 0; j < c_line_size; j++) begin
                    r_data[i][j] <= '0;
                end
            end
            r_valid    <= '0;
            r_dirty    <= '0;
            r_cnt      <= '0;
            r_fill_tag <= '0;
            r_fill_way <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_store) begin
                r_data[w_hit_way][bus.word_i] <= w_merged;
                r_dirty[w_hit_way]            <= 1'b1;
            end
            if (w_start) begin
                r_fill_tag        <= bus.tag_i;
                r_fill_way        <= w_victim;
                r_cnt             <= '0;
                r_valid[w_victim] <= 1'b0;
            end
            if (w_beat) begin
                r_data[r_fill_way][r_cnt] <= bus.refill_data_i;
                r_cnt                     <= r_cnt + c_word_w'(1);
            end
            if (w_last) begin
                r_tag[r_fill_way]   <= r_fill_tag;
                r_valid[r_fill_way] <= 1'b1;
                r_dirty[r_fill_way] <= 1'b0;
            end
            if (w_touch) begin
                for (int i = 0; i < WAYS; i++) begin
                    if (c_ww'(i) == w_touch_way) begin
                        r_age[i] <= '0;
                    end else if (r_age[i] < r_age[w_touch_way]) begin
                        r_age[i] <= r_age[i] + c_ww'(1);
                    end
                end
            end
        end
    end

    assign bus.hit_o          = w_hit;
    assign bus.hit_way_o      = w_hit_way;
    assign bus.read_data_o    = w_hit ? r_data[w_hit_way][bus.word_i] : 32'd0;
    assign bus.victim_way_o   = w_victim;
    assign bus.victim_valid_o = r_valid[w_victim];
    assign bus.victim_dirty_o = r_dirty[w_victim];
    assign bus.victim_tag_o   = r_tag[w_victim];
    assign bus.wb_data_o      = r_data[w_victim][bus.wb_word_i];
    assign bus.busy_o         = (r_state == S_FILL);
    assign bus.refill_done_o  = r_done;

endmodule
`default_nettype wire

// File: doc/cache_set.md
# cache_set

Parametrised N-way set-associative cache set for the data/instruction caches: holds `WAYS` lines (tag, valid, dirty, word array) for one index. It provides same-cycle tag lookup and read, byte-masked store-hit writes, and true-LRU victim selection. A sequential refill engine fills the victim line one word per beat. The cache controller instantiates one per set and drives writeback and refill.

## Interface
- `TAG_WIDTH`, default `CACHE_T`: tag bits.
- `OFFSET_WIDTH`, default `CACHE_B` (≥3): byte-offset bits. `LINE_SIZE = 2**(OFFSET_WIDTH-2)` words per line.
- `WAYS`, default 4: associativity. Power of two, ≥2. `WW = $clog2(WAYS)`.
- `clk_i` in 1: clock, all state updates on rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `tag_i` in TAG_WIDTH: lookup tag. Also the refill tag, captured at refill start.
- `word_i` in OFFSET_WIDTH-2: word index for lookup read and store.
- `access_en_i` in 1: a real access is occurring. A hit with this high updates LRU.
- `write_en_i` in 1: store request. Effective only on a hit in IDLE.
- `byte_en_i` in 4: byte mask for the store. Bit k covers bits [8k+7:8k].
- `write_data_i` in 32: store data.
- `hit_o` out 1: some valid way's tag equals `tag_i`.
- `hit_way_o` out WW: index of the hitting way. 0 when no hit.
- `read_data_o` out 32: word `word_i` of the hit way. 0 when no hit.
- `victim_way_o`, `victim_valid_o`, `victim_dirty_o`, `victim_tag_o` out WW/1/1/TAG_WIDTH: current replacement candidate and its metadata.
- `wb_word_i` in OFFSET_WIDTH-2: word index for victim writeback readout.
- `wb_data_o` out 32: word `wb_word_i` of the victim way.
- `refill_start_i` in 1: begin refilling the victim way with tag `tag_i`.
- `refill_valid_i` in 1: refill data beat valid.
- `refill_data_i` in 32: refill beat data.
- `busy_o` out 1: refill in progress.
- `refill_done_o` out 1: one-cycle pulse after the last refill beat is written.

## Operation
- **State machine:**
  - IDLE → FILL on `refill_start_i`. On entry, capture `tag_i`, `victim_way_o` and the beat counter (set to 0), and clear the victim's valid bit.
  - FILL, each `refill_valid_i`: write `refill_data_i` to word[counter] of the captured way, then increment the counter.
  - FILL, beat with counter == LINE_SIZE-1: set tag = captured tag, valid = 1, dirty = 0; make the way MRU; return to IDLE; pulse `refill_done_o` next cycle.
- **Lookup:** combinational over all ways.
  - At most one way can match; the controller guarantees this.
  - In FILL, `hit_o` is forced to 0.
- **Store hit (IDLE only):** at the edge, write the enabled bytes of `write_data_i` into word `word_i` of the hit way and set its dirty bit. Other bytes are unchanged.
- **LRU:**
  - Each way has a WW-bit age; 0 is MRU and WAYS-1 is LRU. Ages are always a permutation of 0..WAYS-1.
  - On touching way w (an access hit in IDLE, or refill completion): every way with age < age[w] increments, then age[w] becomes 0.
- **Victim:** the lowest-index invalid way if one exists; otherwise the way with age WAYS-1. Computed combinationally; frozen to the captured way while in FILL.
- **Ignored inputs, with no state change:**
  - `refill_start_i` in FILL.
  - `refill_valid_i` in IDLE.
  - `write_en_i` or `access_en_i` in FILL or on a miss.
- **Reset (`rst_ni` low at an edge), including mid-refill:**
  - State IDLE, counter 0, all data/tag/valid/dirty cleared.
  - age[i] = i; `busy_o` = 0; `refill_done_o` = 0.
  - Resulting outputs: `hit_o` 0, `hit_way_o` 0, `read_data_o` 0, victim way 0 with valid/dirty/tag 0, `wb_data_o` 0.

## Timing
- Lookup, read and victim outputs are combinational in the same cycle. Store data is visible on the cycle after the write edge.
- `busy_o` is registered: high from the cycle after the start edge until the cycle after the last-beat edge.
- Minimum refill is LINE_SIZE+1 edges including the start edge. `refill_valid_i` gaps stall the counter.
- A beat asserted in the same cycle as `refill_start_i` is not written.
- `refill_done_o` is high exactly one cycle, coincident with the first cycle `busy_o` is 0.

## Test plan
Parameters for all scenarios: WAYS=4, OFFSET_WIDTH=4, TAG_WIDTH=24.
- **Reset then lookup:** `tag_i`=0x000000 → `hit_o`=0; victim way 0, `victim_valid_o`=0; `busy_o`=0.
- **Refill with a gap:** refill tag 0xABCDEF, beats 0x11,0x22,(gap),0x33,0x44 → `refill_done_o` pulses once after beat 4. Then a lookup with word 2 gives `hit_o`=1, `hit_way_o`=0, `read_data_o`=0x33, dirty 0.
- **Store hit:** `byte_en_i`=4'b0101, data 0xAABBCCDD to word 1 (old value 0x22) → word reads 0x00BB00DD, dirty 1.
- **LRU victim:** fill ways 0–3 with tags 1–4, access tag 1 → victim way 1. Refill tag 5 → evicts tag 2, and the next victim is way 2.
- **Reset mid-refill:** deassert then reassert reset after 2 beats → `busy_o`=0, no `refill_done_o`, all lookups miss, victim way 0.
- **Ignored inputs:** `refill_start_i` during FILL and a store during FILL → neither the captured tag nor any data changes.
